tick_scheduler: RTL and testbench

Multi-channel tick-enable scheduler for the 100 MHz system clock domain. It generates one-cycle `tick` enable pulses and 50%-duty square waves on several channels, each with a runtime-programmable divide value. The divide values are reconfigured through a valid/ready port, and updates are applied glitch-free at tick boundaries. It feeds display scan, debounce, audio and game-timer logic with enables, so no derived clocks are needed.

---
 rtl/tick_scheduler.sv | 113 +++++++++++
 tb/tb_tick_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// Multi-channel tick-enable scheduler: per-channel programmable divider producing
// one-cycle tick enables and 50%-duty square waves, with glitch-free reconfiguration.
module tick_scheduler #(
    parameter int CH          = 4,
    parameter int W           = 27,
    parameter int DEFAULT_DIV = 50000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [$clog2(CH)-1:0]  cfg_chan,
    input  logic [W-1:0]           cfg_div,
    input  logic                   cfg_en,
    input  logic                   sync_start,
    output logic [CH-1:0]          tick,
    output logic [CH-1:0]          sq,
    output logic [CH-1:0]          pending
);

    localparam int CW = $clog2(CH);

    logic         en_r      [CH];
    logic [W-1:0] div_r     [CH];
    logic [W-1:0] cnt_r     [CH];
    logic [W-1:0] p_div_r   [CH];
    logic         p_en_r    [CH];
    logic         pending_r [CH];
    logic         tick_r    [CH];
    logic         sq_r      [CH];

    logic accept_s;

    // Handshake: a channel accepts a new request only while its pending slot is free
    always_comb begin
        cfg_ready = ~pending_r[cfg_chan];
        accept_s  = cfg_valid && cfg_ready;
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [W-1:0] d_s;
        logic         wrap_s;
        logic         acc_s;

        // Effective divide (0 behaves as 1), wrap detect and per-channel accept decode
        always_comb begin
            if (div_r[i] == {W{1'b0}}) begin
                d_s = W'(1);
            end else begin
                d_s = div_r[i];
            end
            wrap_s = en_r[i] && (cnt_r[i] == (d_s - W'(1)));
            acc_s  = accept_s && (cfg_chan == CW'(i));
        end

        // Channel counter, tick/square generation and deferred update application
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                en_r[i]      <= 1'b0;
                div_r[i]     <= W'(DEFAULT_DIV);
                cnt_r[i]     <= {W{1'b0}};
                p_div_r[i]   <= {W{1'b0}};
                p_en_r[i]    <= 1'b0;
                pending_r[i] <= 1'b0;
                tick_r[i]    <= 1'b0;
                sq_r[i]      <= 1'b0;
            end else if (!en_r[i]) begin
                // Idle channel: updates apply immediately, outputs held low
                cnt_r[i]  <= {W{1'b0}};
                tick_r[i] <= 1'b0;
                sq_r[i]   <= 1'b0;
                if (acc_s) begin
                    div_r[i] <= cfg_div;
                    en_r[i]  <= cfg_en;
                end else begin
                    div_r[i] <= div_r[i];
                    en_r[i]  <= en_r[i];
                end
            end else begin
                if (acc_s) begin
                    p_div_r[i]   <= cfg_div;
                    p_en_r[i]    <= cfg_en;
                    pending_r[i] <= 1'b1;
                end
                // sync_start wins over a coincident wrap: no tick, update stays pending
                if (sync_start) begin
                    cnt_r[i]  <= {W{1'b0}};
                    tick_r[i] <= 1'b0;
                    sq_r[i]   <= 1'b0;
                end else if (wrap_s) begin
                    cnt_r[i]  <= {W{1'b0}};
                    tick_r[i] <= 1'b1;
                    if (pending_r[i]) begin
                        div_r[i]     <= p_div_r[i];
                        en_r[i]      <= p_en_r[i];
                        pending_r[i] <= 1'b0;
                        sq_r[i]      <= p_en_r[i] ? ~sq_r[i] : 1'b0;
                    end else begin
                        sq_r[i] <= ~sq_r[i];
                    end
                end else begin
                    cnt_r[i]  <= cnt_r[i] + W'(1);
                    tick_r[i] <= 1'b0;
                end
            end
        end

        assign tick[i]    = tick_r[i];
        assign sq[i]      = sq_r[i];
        assign pending[i] = pending_r[i];
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed testbench for tick_scheduler: hand-computed tick/sq/pending/cfg_ready
// expectations sampled on the falling edge.
module tb_tick_scheduler;

    localparam int CH = 4;
    localparam int W  = 27;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          cfg_valid  = 1'b0;
    logic          cfg_en     = 1'b0;
    logic          sync_start = 1'b0;
    logic [1:0]    cfg_chan   = 2'd0;
    logic [W-1:0]  cfg_div    = '0;
    logic          cfg_ready;
    logic [CH-1:0] tick;
    logic [CH-1:0] sq;
    logic [CH-1:0] pending;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tick_scheduler #(.CH(CH), .W(W), .DEFAULT_DIV(50000000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_chan   (cfg_chan),
        .cfg_div    (cfg_div),
        .cfg_en     (cfg_en),
        .sync_start (sync_start),
        .tick       (tick),
        .sq         (sq),
        .pending    (pending)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [W-1:0] dv, input logic e);
        cfg_chan  = ch;
        cfg_div   = dv;
        cfg_en    = e;
        cfg_valid = 1'b1;
    endtask

    task automatic do_reset();
        cfg_valid  = 1'b0;
        sync_start = 1'b0;
        rst_n      = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_sq", 32'(sq), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_div0", 32'(dut.div_r[0]), 32'd50000000);

        // ch0 div=4: ticks after E+4, E+8, E+12; sq period 8
        cfg(2'd0, 27'd4, 1'b1);
        cyc();
        cfg_valid = 1'b0;
        chk("t1_pend0_k0", 32'(pending[0]), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk("t1_tick0", 32'(tick[0]), (k % 4 == 0) ? 32'd1 : 32'd0);
            chk("t1_sq0", 32'(sq[0]), ((k / 4) % 2 == 1) ? 32'd1 : 32'd0);
            chk("t1_pend0", 32'(pending[0]), 32'd0);
        end

        // ch1 div=10, shrink to 3 three cycles after a tick; held request while not ready
        do_reset();
        cfg(2'd1, 27'd10, 1'b1);
        cyc();
        cfg_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk("t2_tick1_pre", 32'(tick[1]), (k == 10) ? 32'd1 : 32'd0);
        end
        cfg(2'd1, 27'd3, 1'b1);
        cyc();
        cfg_valid = 1'b0;
        chk("t2_pend1_acc", 32'(pending[1]), 32'd1);
        chk("t2_ready_acc", 32'(cfg_ready), 32'd0);
        chk("t2_tick1_acc", 32'(tick[1]), 32'd0);
        for (int k = 14; k <= 26; k++) begin
            cyc();
            chk("t2_ready", 32'(cfg_ready), (k >= 20) ? 32'd1 : 32'd0);
            chk("t2_pend1", 32'(pending[1]), (k < 20) ? 32'd1 : 32'd0);
            chk("t2_tick1", 32'(tick[1]), (k == 20 || k == 23 || k == 26) ? 32'd1 : 32'd0);
            if (k == 14) cfg(2'd1, 27'd2, 1'b0);
            if (k == 19) cfg_valid = 1'b0;
        end

        // ch2 div=0 behaves as 1: tick constantly high, sq toggles every cycle
        do_reset();
        cfg(2'd2, 27'd0, 1'b1);
        cyc();
        cfg_valid = 1'b0;
        chk("t3_tick2_k0", 32'(tick[2]), 32'd0);
        chk("t3_sq2_k0", 32'(sq[2]), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk("t3_tick2", 32'(tick[2]), 32'd1);
            chk("t3_sq2", 32'(sq[2]), 32'(k % 2));
        end

        // ch0 div=5, ch3 div=7, then sync_start realigns both
        do_reset();
        cfg(2'd0, 27'd5, 1'b1);
        cyc();
        cfg(2'd3, 27'd7, 1'b1);
        cyc();
        cfg_valid = 1'b0;
        for (int k = 2; k <= 8; k++) cyc();
        chk("t4_sq0_pre", 32'(sq[0]), 32'd1);
        chk("t4_tick3_pre", 32'(tick[3]), 32'd1);
        chk("t4_sq3_pre", 32'(sq[3]), 32'd1);
        sync_start = 1'b1;
        cyc();
        sync_start = 1'b0;
        chk("t4_tick_sync", 32'(tick), 32'd0);
        chk("t4_sq_sync", 32'(sq), 32'd0);
        for (int j = 1; j <= 7; j++) begin
            cyc();
            chk("t4_tick0", 32'(tick[0]), (j == 5) ? 32'd1 : 32'd0);
            chk("t4_tick3", 32'(tick[3]), (j == 7) ? 32'd1 : 32'd0);
            chk("t4_sq0", 32'(sq[0]), (j >= 5) ? 32'd1 : 32'd0);
            chk("t4_sq3", 32'(sq[3]), (j >= 7) ? 32'd1 : 32'd0);
        end

        // ch0 div=6 with en=0 update pending; async reset clears everything
        do_reset();
        cfg(2'd0, 27'd6, 1'b1);
        cyc();
        cfg_valid = 1'b0;
        for (int k = 1; k <= 5; k++) cyc();
        cfg(2'd0, 27'd9, 1'b0);
        cyc();
        cfg_valid = 1'b0;
        chk("t5_tick0_pre", 32'(tick[0]), 32'd1);
        chk("t5_sq0_pre", 32'(sq[0]), 32'd1);
        chk("t5_pend0_pre", 32'(pending[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_tick_rst", 32'(tick), 32'd0);
        chk("t5_sq_rst", 32'(sq), 32'd0);
        chk("t5_pend_rst", 32'(pending), 32'd0);
        cyc();
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk("t5_tick0_post", 32'(tick[0]), 32'd0);
            chk("t5_pend0_post", 32'(pending[0]), 32'd0);
        end
        chk("t5_div0_post", 32'(dut.div_r[0]), 32'd50000000);
        chk("t5_en0_post", 32'(dut.en_r[0]), 32'd0);

        // ch1 div=4 with en=0 update pending: one final tick, then silent with sq=0
        do_reset();
        cfg(2'd1, 27'd4, 1'b1);
        cyc();
        cfg(2'd1, 27'd7, 1'b0);
        cyc();
        cfg_valid = 1'b0;
        chk("t6_pend1_acc", 32'(pending[1]), 32'd1);
        for (int k = 2; k <= 14; k++) begin
            cyc();
            chk("t6_tick1", 32'(tick[1]), (k == 4) ? 32'd1 : 32'd0);
            chk("t6_sq1", 32'(sq[1]), 32'd0);
            chk("t6_pend1", 32'(pending[1]), (k < 4) ? 32'd1 : 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
